// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcodes, FSM states,
// opcode classes and the ALU/write-back select codes.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_I      = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JAL    = 3'd5
    } op_class_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_ARITH  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Returns {ALUOp, ALUSrc} for an opcode class.
    function automatic logic [2:0] alu_ctrl(input op_class_t cls);
        case (cls)
            CL_R:      alu_ctrl = {ALU_ARITH, 1'b0};
            CL_I:      alu_ctrl = {ALU_ARITH, 1'b1};
            CL_BRANCH: alu_ctrl = {ALU_BRANCH, 1'b0};
            default:   alu_ctrl = {ALU_ADD, 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; flags unknown opcodes and reserved branch funct3.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output op_class_t  op_class,
    output logic       illegal
);

    always_comb begin
        op_class = CL_R;
        illegal  = 1'b0;
        case (opcode)
            OP_R:      op_class = CL_R;
            OP_I:      op_class = CL_I;
            OP_LOAD:   op_class = CL_LOAD;
            OP_STORE:  op_class = CL_STORE;
            OP_BRANCH: begin
                op_class = CL_BRANCH;
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL:    op_class = CL_JAL;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky trap
// state and a retired-instruction counter.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             zero,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [1:0]       ALUOp,
    output logic             ALUSrc,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic             pc_src,
    output logic             illegal,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    state_t           state_reg;
    op_class_t        class_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] instret_reg;

    op_class_t        dec_class;
    logic             dec_illegal;

    logic             unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    ctrl_decode u_decode (
        .opcode   (instr[6:0]),
        .funct3   (instr[14:12]),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            class_reg   <= CL_R;
            illegal_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            if (pc_we)
                instret_reg <= instret_reg + CNT_W'(1);
            case (state_reg)
                S_IDLE:  state_reg <= S_FETCH;
                S_FETCH: if (imem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    class_reg <= dec_class;
                    if (dec_illegal) begin
                        illegal_reg <= 1'b1;
                        state_reg   <= S_TRAP;
                    end else begin
                        state_reg   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (class_reg)
                        CL_R, CL_I:         state_reg <= S_WB;
                        CL_LOAD, CL_STORE:  state_reg <= S_MEM;
                        default:            state_reg <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready)
                        state_reg <= (class_reg == CL_STORE) ? S_FETCH : S_WB;
                end
                S_WB:    state_reg <= S_FETCH;
                default: state_reg <= S_TRAP;
            endcase
        end
    end

    // Outputs decode from the registered state/class; ir_we, the branch pc_src and
    // the store retire in the ready cycle follow their inputs directly.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ALUOp    = ALU_ADD;
        ALUSrc   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WB_ALU;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                {ALUOp, ALUSrc} = alu_ctrl(class_reg);
                if (class_reg == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_src = zero;
                end else if (class_reg == CL_JAL) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                    reg_we = 1'b1;
                    wb_sel = WB_PC4;
                end
            end
            S_MEM: begin
                {ALUOp, ALUSrc} = alu_ctrl(class_reg);
                dmem_req = 1'b1;
                dmem_we  = (class_reg == CL_STORE);
                pc_we    = (class_reg == CL_STORE) && dmem_ready;
            end
            S_WB: begin
                {ALUOp, ALUSrc} = alu_ctrl(class_reg);
                reg_we = 1'b1;
                wb_sel = (class_reg == CL_LOAD) ? WB_MEM : WB_ALU;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_reg;
    assign state_o = state_reg;
    assign instret = instret_reg;

endmodule
